table_sweep_ctrl: RTL and testbench
===================================

Name: table_sweep_ctrl

Overview:
- Sequencer for the 3-input truth-table block (inputs w, x, y; output z).
- On start, drives all 2^3 input combinations in ascending order and waits a programmable settle time after each.
- Samples z into a captured truth-table word and compares it against an expected table.
- Reports pass/fail and the first failing index; used as the on-chip self-check wrapper around the table logic.

Parameters:
- SETTLE_CYC, 2, cycles spent in SETTLE after each new vector (0 skips SETTLE); range 0..15.
- EXP_TT, 8'h80, expected truth table; bit i = expected z for {w,x,y} = i.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- abort  input  1  cancel sweep; returns to IDLE next cycle
- z_in  input  1  z output of the table block
- w_out  output  1  drives table input w (idx bit 2)
- x_out  output  1  drives table input x (idx bit 1)
- y_out  output  1  drives table input y (idx bit 0)
- busy  output  1  high while in DRIVE/SETTLE/SAMPLE
- done  output  1  one-cycle pulse when sweep completes
- pass  output  1  captured table == EXP_TT; valid from done, held until next start
- tt  output  8  captured truth table, bit i = sampled z at idx i
- first_fail  output  3  lowest idx with tt[i] != EXP_TT[i]; 0 when pass=1

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, settle count=0. Outputs w_out/x_out/y_out=0, busy=0, done=0, pass=0, tt=8'h00, first_fail=0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 -> DRIVE.
  - On the same edge: idx=0, tt cleared to 0, pass cleared.
- DRIVE (1 cycle):
  - Registered {w_out,x_out,y_out} = idx.
  - -> SETTLE if SETTLE_CYC>0, else -> SAMPLE.
  - Load settle count = SETTLE_CYC-1.
- SETTLE:
  - Decrement settle count each cycle.
  - When the count reaches 0, -> SAMPLE. This gives exactly SETTLE_CYC cycles in SETTLE.
- SAMPLE (1 cycle):
  - tt[idx] <= z_in. z_in is sampled directly, with no synchronizer; it is combinational from the registered drives.
  - idx==7 -> FINISH; otherwise idx++ and -> DRIVE.
- FINISH (1 cycle):
  - done=1.
  - pass = (tt == EXP_TT), using the fully updated tt.
  - first_fail = priority-encoded lowest set bit of (tt ^ EXP_TT).
  - -> IDLE.
- Output timing:
  - done, pass and first_fail are registered outputs of the FINISH evaluation.
  - done is high for exactly one cycle.
  - pass and first_fail hold until the next start.
- Latency:
  - Each vector takes SETTLE_CYC+2 cycles.
  - start accepted at edge T0 -> done high during cycle T0 + 8*(SETTLE_CYC+2) + 1.
  - Default SETTLE_CYC=2: done at T0+33.
- busy: high from the first DRIVE cycle through the last SAMPLE cycle; low in IDLE and FINISH.
- Drives: w_out/x_out/y_out keep their last value (idx 7 = 1,1,1) after a sweep until the next DRIVE or reset.
- abort:
  - abort=1 in any non-IDLE state -> IDLE next edge; abort takes priority over all transitions.
  - No done pulse.
  - tt keeps its partial contents; pass=0; drives return to 0.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, so the block stays in IDLE.
- rst_n asserted mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
1. Reset, then start with z_in = w_out&x_out&y_out, defaults -> tt=8'h80, pass=1, first_fail=0; done pulses exactly 33 cycles after start edge; busy high for 32 cycles.
2. z_in = w_out|y_out with EXP_TT=8'h80 -> tt=8'hFA, pass=0, first_fail=1; drive sequence observed as 000,001,...,111.
3. SETTLE_CYC=0, z_in = x_out -> each vector 2 cycles, done at start+17, tt=8'hCC.
4. Assert abort when idx=4 in SETTLE -> IDLE next cycle, no done, busy=0, drives=000, pass=0, tt[3:0] holds sampled values; a following start completes normally.
5. Pulse start during busy, and start+abort together in IDLE -> no restart and no state change, respectively.
6. Deassert rst_n mid-SAMPLE -> all outputs 0 immediately (asynchronous); after release, IDLE with no spurious done.

Source files
------------

// File: rtl/table_sweep_ctrl.sv
// table_sweep_ctrl: on-chip self-check sequencer for the 3-input truth-table
// block. It walks {w,x,y} through 0..7, waits SETTLE_CYC cycles after each
// vector, samples z into tt and grades the result against EXP_TT.
module table_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  EXP_TT     = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       z_in,
  output logic       w_out,
  output logic       x_out,
  output logic       y_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt,
  output logic [2:0] first_fail
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TT_W  = 8;

  // SETTLE is skipped entirely when SETTLE_CYC is 0, so the load value only
  // matters for non-zero settings; clamp it to avoid an underflowed constant.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
  localparam bit HAS_SETTLE = (SETTLE_CYC > 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [TT_W-1:0]  diff_c;
  logic [IDX_W-1:0] first_fail_c;

  // Lowest index where the captured table disagrees with the expected one.
  always_comb begin
    diff_c       = tt ^ EXP_TT;
    first_fail_c = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff_c[i]) first_fail_c = IDX_W'(i);
    end
  end

  // Sweep FSM with registered drives, status and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      w_out      <= 1'b0;
      x_out      <= 1'b0;
      y_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      tt         <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Cancel: keep partial tt, drop drives and verdict, no done pulse.
        state <= IDLE;
        busy  <= 1'b0;
        pass  <= 1'b0;
        w_out <= 1'b0;
        x_out <= 1'b0;
        y_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= DRIVE;
              idx        <= '0;
              tt         <= '0;
              pass       <= 1'b0;
              first_fail <= '0;
              busy       <= 1'b1;
            end
          end
          DRIVE: begin
            {w_out, x_out, y_out} <= idx;
            settle_cnt            <= SETTLE_LOAD;
            state                 <= HAS_SETTLE ? SETTLE : SAMPLE;
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              state <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - CNT_W'(1);
            end
          end
          SAMPLE: begin
            tt[idx] <= z_in;
            if (idx == IDX_W'(7)) begin
              state <= FINISH;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= DRIVE;
            end
          end
          FINISH: begin
            done       <= 1'b1;
            pass       <= (tt == EXP_TT);
            first_fail <= first_fail_c;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_table_sweep_ctrl.sv
// Bench for table_sweep_ctrl: two instances (default settle, zero settle),
// each wrapped around a small behavioural truth-table selected by zmode.
module tb_table_sweep_ctrl;

  typedef struct packed {
    logic [7:0] tt;
    logic       pass;
    logic [2:0] ff;
  } result_t;

  logic clk;
  logic rst_n;

  logic       start_a, abort_a, z_a, w_a, x_a, y_a, busy_a, done_a, pass_a;
  logic [7:0] tt_a;
  logic [2:0] ff_a;
  logic       start_b, abort_b, z_b, w_b, x_b, y_b, busy_b, done_b, pass_b;
  logic [7:0] tt_b;
  logic [2:0] ff_b;

  int zmode_a;
  int n_cmp;
  int n_mis;
  result_t sb_q[$];

  table_sweep_ctrl #(.SETTLE_CYC(2), .EXP_TT(8'h80)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .z_in(z_a),
    .w_out(w_a), .x_out(x_a), .y_out(y_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .tt(tt_a), .first_fail(ff_a)
  );

  table_sweep_ctrl #(.SETTLE_CYC(0), .EXP_TT(8'h80)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .z_in(z_b),
    .w_out(w_b), .x_out(x_b), .y_out(y_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .tt(tt_b), .first_fail(ff_b)
  );

  assign z_a = (zmode_a == 0) ? (w_a & x_a & y_a) : (w_a | y_a);
  assign z_b = x_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table-under-test model: 0 = w&x&y, 1 = w|y, 2 = x.
  function automatic logic zf(input int mode, input logic [2:0] i);
    case (mode)
      0:       return i[2] & i[1] & i[0];
      1:       return i[2] | i[0];
      default: return i[1];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start_a = v; else start_b = v;
  endtask

  // Full sweep on one instance; optional extra start pulse while busy.
  task automatic run_sweep(input int inst, input int zmode, input int s, input bit poke);
    result_t    e;
    result_t    got;
    logic [7:0] ett;
    int         busy_cnt;
    int         done_cnt;
    int         done_cyc;
    int         lim;
    logic [2:0] drv;
    logic       bsy;
    logic       dn;
    ett = '0;
    for (int i = 0; i < 8; i++) ett[i] = zf(zmode, 3'(i));
    e.tt   = ett;
    e.pass = (ett == 8'h80);
    e.ff   = 3'd0;
    for (int i = 7; i >= 0; i--) if (ett[i] != ((i == 7) ? 1'b1 : 1'b0)) e.ff = 3'(i);
    sb_q.push_back(e);
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    lim      = 8 * (s + 2) + 4;
    set_start(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(inst, 1'b0);
    for (int cyc = 0; cyc <= lim; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (poke && cyc == 10) set_start(inst, 1'b1);
      if (poke && cyc == 11) set_start(inst, 1'b0);
      drv = (inst == 0) ? {w_a, x_a, y_a} : {w_b, x_b, y_b};
      bsy = (inst == 0) ? busy_a : busy_b;
      dn  = (inst == 0) ? done_a : done_b;
      if (bsy) busy_cnt++;
      if ((cyc % (s + 2)) == (s + 1) && cyc < 8 * (s + 2))
        check($sformatf("drive_v%0d", cyc / (s + 2)), 32'(drv), 32'(cyc / (s + 2)));
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = (inst == 0) ? {tt_a, pass_a, ff_a} : {tt_b, pass_b, ff_b};
            check("result_tt", 32'(got.tt), 32'(e.tt));
            check("result_pass", 32'(got.pass), 32'(e.pass));
            check("result_first_fail", 32'(got.ff), 32'(e.ff));
          end
        end
      end
    end
    if (done_cyc < 0) void'(sb_q.pop_front());
    check("done_latency", 32'(done_cyc), 32'(8 * (s + 2) + 1));
    check("done_pulse_count", 32'(done_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(8 * (s + 2)));
    // Verdict must hold after the pulse.
    got = (inst == 0) ? {tt_a, pass_a, ff_a} : {tt_b, pass_b, ff_b};
    check("pass_held", 32'(got.pass), 32'(e.pass));
  endtask

  initial begin
    int dcnt;
    n_cmp   = 0;
    n_mis   = 0;
    zmode_a = 0;
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tt", 32'(tt_a), 32'h0);
    check("rst_outs", 32'({w_a, x_a, y_a, busy_a, done_a, pass_a, ff_a}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AND table, default settle: passes.
    run_sweep(0, 0, 2, 1'b0);
    // OR-ish table with a start pulse mid-sweep that must be ignored.
    zmode_a = 1;
    run_sweep(0, 1, 2, 1'b1);
    // Zero-settle instance, z = x.
    run_sweep(1, 2, 0, 1'b0);

    // Abort during SETTLE of vector 4.
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (17) @(negedge clk);
    check("abort_pre_drive", 32'({w_a, x_a, y_a}), 32'd4);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_drives", 32'({w_a, x_a, y_a}), 32'd0);
    check("abort_pass", 32'(pass_a), 32'd0);
    check("abort_tt", 32'(tt_a), 32'h0A);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_a || busy_a) dcnt++;
    end
    check("abort_quiet", 32'(dcnt), 32'd0);
    run_sweep(0, 1, 2, 1'b0);

    // start and abort together in IDLE: nothing happens, tt untouched.
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("idle_abort_busy", 32'(busy_a), 32'd0);
    check("idle_abort_tt", 32'(tt_a), 32'hFA);
    repeat (2) @(negedge clk);
    check("idle_abort_busy_later", 32'(busy_a), 32'd0);

    // Asynchronous reset during SAMPLE of vector 2.
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (11) @(negedge clk);
    check("rst_mid_pre_tt", 32'(tt_a), 32'h02);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 32'({w_a, x_a, y_a, busy_a, done_a, pass_a, ff_a}), 32'h0);
    check("rst_mid_tt", 32'(tt_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a || busy_a || done_b || busy_b) dcnt++;
    end
    check("rst_release_quiet", 32'(dcnt), 32'd0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
